// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR access path.
//   - CSR address constants for the implemented machine-mode registers
//   - csr_op_e:        Zicsr funct3 encodings
//   - csr_acc_state_e: state encoding of the CSR access sequencer
//   - csr_addr_supported(): membership test for the implemented CSR set
package csr_pkg;

  localparam int CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_MHARTID  = 12'hF14;

  // funct3[2] selects the immediate form, funct3[1:0] the operation kind.
  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_acc_state_e;

  function automatic logic csr_addr_supported(input logic [CSR_ADDR_W-1:0] addr);
    logic hit;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID: hit = 1'b1;
      default:                                               hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational read-modify-write data path for Zicsr operations.
//   op      - Zicsr operation (immediate and register forms behave alike)
//   old     - current CSR value
//   operand - rs1 value or zero-extended uimm
//   wdata   - value to be written back to the CSR
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e         op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] wdata
);

  always_comb begin
    wdata = operand;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: wdata = operand;
      CSR_OP_RS, CSR_OP_RSI: wdata = old | operand;
      CSR_OP_RC, CSR_OP_RCI: wdata = old & ~operand;
      default:               wdata = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the machine-mode CSR file port.
// Takes one decoded Zicsr instruction at a time, reads the CSR, optionally
// writes it back, and returns the old value (or an illegal indication).
//
// Ports:
//   ctrl_clk, ctrl_reset_n       clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_funct3, req_csr          Zicsr funct3 and CSR address
//   req_rs1_idx, req_rs1_val     rs1 index (uimm for immediate forms), rs1 value
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_illegal     old CSR value (0 if illegal), illegal flag
//   csr_addr, csr_wdata, csr_wen CSR file address, write data, write enable
//   csr_rdata                    CSR file combinational read data
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_ready is high only in IDLE; resp_valid, resp_rdata and resp_illegal are
// held stable from the first RESP cycle until the edge where resp_ready is high.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = CSR_ADDR_W
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_csr,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_rs1_val,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_wen,
  input  logic [XLEN-1:0]   csr_rdata
);

  csr_acc_state_e    state_q, state_d;
  logic [2:0]        op_q;
  logic [CSR_AW-1:0] csr_q;
  logic [4:0]        idx_q;
  logic [XLEN-1:0]   operand_q;
  logic [XLEN-1:0]   old_q;
  logic              illegal_q;

  logic              write_intent_c;
  logic              illegal_c;
  logic [XLEN-1:0]   alu_wdata;

  // RS/RC with rs1=x0 (or uimm=0) are pure reads; RW always writes.
  assign write_intent_c = (op_q[1:0] == 2'b01) || (idx_q != 5'd0);

  // csr[11:10]==11 marks the read-only CSR space.
  assign illegal_c = (op_q[1:0] == 2'b00)
                  || !csr_addr_supported(csr_q)
                  || (write_intent_c && (csr_q[11:10] == 2'b11));

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op      (csr_op_e'(op_q)),
    .old     (old_q),
    .operand (operand_q),
    .wdata   (alu_wdata)
  );

  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      csr_q     <= '0;
      idx_q     <= '0;
      operand_q <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && req_valid) begin
        op_q      <= req_funct3;
        csr_q     <= req_csr;
        idx_q     <= req_rs1_idx;
        operand_q <= req_funct3[2] ? XLEN'(req_rs1_idx) : req_rs1_val;
      end
      if (state_q == ST_READ) begin
        old_q     <= csr_rdata;
        illegal_q <= illegal_c;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_illegal = 1'b0;
    resp_rdata   = '0;
    csr_wen      = 1'b0;
    csr_addr     = '0;
    csr_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_READ;
      end
      ST_READ: begin
        csr_addr = csr_q;
        state_d  = (!illegal_c && write_intent_c) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        csr_addr  = csr_q;
        csr_wen   = 1'b1;
        csr_wdata = alu_wdata;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        resp_rdata   = illegal_q ? '0 : old_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
